// File: rtl/reg_write_arbiter.sv
// Purpose: arbitrates two register-file write requesters onto one registered write port (round-robin or fixed priority).
// Latency: one cycle from the accepting edge to the write_enable_3/sel_3/val_3 presentation.
// Backpressure: reqN_ready is combinational, granted to at most one valid requester per cycle, and held low during reset.
module reg_write_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [4:0]  req0_sel,
    input  logic [31:0] req0_val,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_sel,
    input  logic [31:0] req1_val,
    output logic        req1_ready,
    output logic        write_enable_3,
    output logic [4:0]  sel_3,
    output logic [31:0] val_3,
    output logic        grant_id,
    output logic [7:0]  conflict_cnt
);

    logic        we_q,    we_d;
    logic [4:0]  sel_q,   sel_d;
    logic [31:0] val_q,   val_d;
    logic        gid_q,   gid_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        last_q,  last_d;

    logic        both_vld;
    logic        gnt0;
    logic        gnt1;
    logic        xfer;
    logic [4:0]  win_sel;
    logic [31:0] win_val;

    assign both_vld = req0_valid & req1_valid;

    // Ready is gated by rst_n directly so a request pending in reset is never consumed.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (both_vld) begin
                if ((FAIR != 0) && !last_q) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign xfer    = gnt0 | gnt1;
    assign win_sel = gnt1 ? req1_sel : req0_sel;
    assign win_val = gnt1 ? req1_val : req0_val;

    // Write port state only loads from the granted requester, so idle requester data never leaks out.
    always_comb begin
        we_d   = 1'b0;
        sel_d  = sel_q;
        val_d  = val_q;
        gid_d  = gid_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (xfer) begin
            we_d   = (win_sel != 5'd0);
            sel_d  = win_sel;
            val_d  = win_val;
            gid_d  = gnt1;
            last_d = gnt1;
        end
        if (both_vld && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // last_q resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            sel_q  <= 5'd0;
            val_q  <= 32'd0;
            gid_q  <= 1'b0;
            cnt_q  <= 8'd0;
            last_q <= 1'b1;
        end else begin
            we_q   <= we_d;
            sel_q  <= sel_d;
            val_q  <= val_d;
            gid_q  <= gid_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign req0_ready     = gnt0;
    assign req1_ready     = gnt1;
    assign write_enable_3 = we_q;
    assign sel_3          = sel_q;
    assign val_3          = val_q;
    assign grant_id       = gid_q;
    assign conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: round-robin instance on a write scoreboard, fixed-priority instance
// sharing the same request inputs and checked on its ready/counter outputs.
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [4:0]  req0_sel;
    logic [31:0] req0_val;
    logic        req1_valid;
    logic [4:0]  req1_sel;
    logic [31:0] req1_val;

    logic        req0_ready,  req1_ready;
    logic        we3;
    logic [4:0]  sel3;
    logic [31:0] val3;
    logic        gid;
    logic [7:0]  ccnt;

    logic        fp_req0_ready, fp_req1_ready;
    logic        fp_we3;
    logic [4:0]  fp_sel3;
    logic [31:0] fp_val3;
    logic        fp_gid;
    logic [7:0]  fp_ccnt;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] val;
        logic        gid;
    } wr_t;

    wr_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;
    logic exp_we = 1'b0;

    reg_write_arbiter #(.FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_val(req0_val), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_val(req1_val), .req1_ready(req1_ready),
        .write_enable_3(we3), .sel_3(sel3), .val_3(val3), .grant_id(gid), .conflict_cnt(ccnt)
    );

    reg_write_arbiter #(.FAIR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_val(req0_val), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_val(req1_val), .req1_ready(fp_req1_ready),
        .write_enable_3(fp_we3), .sel_3(fp_sel3), .val_3(fp_val3), .grant_id(fp_gid), .conflict_cnt(fp_ccnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse from the round-robin instance must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && we3) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected: got write sel=%0d val=%h, required no write", sel3, val3);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_sel", {27'd0, sel3}, {27'd0, e.sel});
                chk("sb_val", val3, e.val);
                chk("sb_gid", {31'd0, gid}, {31'd0, e.gid});
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v0, input logic [4:0] s0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] s1, input logic [31:0] d1,
                        input logic e0, input logic e1);
        wr_t w;
        req0_valid = v0; req0_sel = s0; req0_val = d0;
        req1_valid = v1; req1_sel = s1; req1_val = d1;
        @(negedge clk);
        chk("we_pulse", {31'd0, we3}, {31'd0, exp_we});
        chk("rdy0", {31'd0, req0_ready}, {31'd0, e0});
        chk("rdy1", {31'd0, req1_ready}, {31'd0, e1});
        chk("fp_rdy0", {31'd0, fp_req0_ready}, {31'd0, v0});
        chk("fp_rdy1", {31'd0, fp_req1_ready}, {31'd0, v1 & ~v0});
        exp_we = 1'b0;
        if (e0 && s0 != 5'd0) begin
            w.sel = s0; w.val = d0; w.gid = 1'b0; sb.push_back(w); exp_we = 1'b1;
        end
        if (e1 && s1 != 5'd0) begin
            w.sel = s1; w.val = d1; w.gid = 1'b1; sb.push_back(w); exp_we = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"},  {31'd0, we3},  32'd0);
        chk({tag, "_sel"}, {27'd0, sel3}, 32'd0);
        chk({tag, "_val"}, val3,          32'd0);
        chk({tag, "_gid"}, {31'd0, gid},  32'd0);
        chk({tag, "_cnt"}, {24'd0, ccnt}, 32'd0);
    endtask

    // Enters at posedge+1, keeps a request pending during reset, releases mid-cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        exp_we = 1'b0;
        req0_valid = 1'b1; req0_sel = 5'd1; req0_val = 32'h0BAD_0BAD;
        req1_valid = 1'b1; req1_sel = 5'd1; req1_val = 32'h0BAD_0BAD;
        #1;
        check_zero("rst");
        @(negedge clk);
        chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_sel = 5'd0; req0_val = 32'd0;
        req1_valid = 1'b0; req1_sel = 5'd0; req1_val = 32'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Request held through reset is taken on the first edge after release.
        step(1'b1, 5'd2, 32'h0000_0022, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();

        // Single requester 1.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
        idle();
        idle();
        chk("hold_we",  {31'd0, we3},  32'd0);
        chk("hold_sel", {27'd0, sel3}, 32'd5);
        chk("hold_val", val3,          32'hDEAD_BEEF);
        chk("hold_gid", {31'd0, gid},  32'd1);

        // Tie after reset: grants 0,1,0,1 with back-to-back writes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd3, 32'hA000_0000 + i, 1'b1, 5'd4, 32'hB000_0000 + i,
                 (i % 2) == 0, (i % 2) == 1);
        end
        chk("tie_cnt", {24'd0, ccnt}, 32'd4);
        chk("fp_tie_cnt", {24'd0, fp_ccnt}, 32'd4);

        // Same destination: later grant (requester 1) must be the last write.
        step(1'b1, 5'd7, 32'h0000_0070, 1'b1, 5'd7, 32'h0000_0071, 1'b1, 1'b0);
        step(1'b1, 5'd7, 32'h0000_0070, 1'b1, 5'd7, 32'h0000_0071, 1'b0, 1'b1);
        idle();
        chk("same_sel", {27'd0, sel3}, 32'd7);
        chk("same_val", val3,          32'h0000_0071);
        chk("same_gid", {31'd0, gid},  32'd1);

        // Fixed priority instance: requester 0 every cycle, count 3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd8, 32'hC000_0000 + i, 1'b1, 5'd9, 32'hD000_0000 + i,
                 (i % 2) == 0, (i % 2) == 1);
        end
        chk("fp_cnt", {24'd0, fp_ccnt}, 32'd3);
        chk("fp_gid", {31'd0, fp_gid},  32'd0);
        chk("fp_val", fp_val3,          32'hC000_0002);

        // Zero register: accepted, no write strobe, data still loaded.
        step(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();
        chk("zero_sel", {27'd0, sel3}, 32'd0);
        chk("zero_val", val3,          32'h0000_1234);
        chk("zero_gid", {31'd0, gid},  32'd0);

        // Saturation of the conflict counter.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 5'd10, i, 1'b1, 5'd11, 32'h0001_0000 + i, (i % 2) == 0, (i % 2) == 1);
            if (i == 254) chk("sat_254", {24'd0, ccnt}, 32'd255);
        end
        chk("sat_cnt", {24'd0, ccnt}, 32'd255);
        chk("fp_sat_cnt", {24'd0, fp_ccnt}, 32'd255);
        idle();

        // Unknown data on idle requesters must not disturb held outputs.
        step(1'b0, 5'bxxxxx, 32'hxxxx_xxxx, 1'b0, 5'bxxxxx, 32'hxxxx_xxxx, 1'b0, 1'b0);
        chk("x_sel", {27'd0, sel3}, 32'd11);
        chk("x_val", val3,          32'h0001_012B);
        chk("x_cnt", {24'd0, ccnt}, 32'd255);

        // Mid-operation reset: registered write is discarded.
        step(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("mid_pre_we", {31'd0, we3}, 32'd1);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        sb.delete();
        exp_we = 1'b0;
        #1;
        check_zero("mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        idle();
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
